// File: rtl/rom_byte_feeder_pkg.sv
// Shared types and helpers for the ROM byte feeder: FSM state encoding,
// bus widths and the endianness-aware lane selector.
package rom_feeder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CSUM_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        EMIT      = 3'd2,
        GAP       = 3'd3,
        TAIL      = 3'd4
    } feeder_state_t;

    // Byte of a ROM word for a given emission lane; lane 0 is the first byte out.
    function automatic logic [BYTE_W-1:0] lane_byte(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        lane,
        input logic              big_endian
    );
        logic [1:0] idx;
        idx = big_endian ? 2'(2'd3 - lane) : lane;
        case (idx)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/rom_byte_feeder_if.sv
// ROM word stream from the bridge-side FIFO into the byte feeder.
interface rom_byte_feeder_if;
    import rom_feeder_pkg::*;

    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (output word_valid, output word_data, input  word_ready);
    modport slave  (input  word_valid, input  word_data, output word_ready);

endinterface

// File: rtl/rom_byte_feeder_pace_counter.sv
// Loadable down-counter used for both the inter-strobe gap and the download tail.
module feeder_pace_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c,
    output logic             zero_next_c
);

    logic [CNT_W-1:0] cnt;

    // Saturates at zero so an idle counter stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c      = (cnt == '0);
    // Lets the owner register a flag that lines up with the cycle the count hits zero.
    assign zero_next_c = load ? (load_val == '0) : (cnt <= CNT_W'(1));

endmodule

// File: rtl/rom_byte_feeder.sv
// Serialises 32-bit ROM words into the paced ioctl byte stream for GameLoader.
// Optional `ROM_FEEDER_CHECKSUM_EN adds a 16-bit running sum of emitted bytes.
module rom_byte_feeder
    import rom_feeder_pkg::*;
#(
    parameter int unsigned WRITE_GAP   = 8,
    parameter int unsigned TAIL_CYCLES = 16,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter int unsigned LEN_W       = 25
) (
    input  logic              clk_ppu_21_47,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    rom_byte_feeder_if.slave  word,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [BYTE_W-1:0] ioctl_dout,
    output logic [LEN_W-1:0]  ioctl_addr,
    output logic              busy,
    output logic              done
`ifdef ROM_FEEDER_CHECKSUM_EN
    ,
    output logic [CSUM_W-1:0] checksum
`endif
);

    // Tail is timed from the last strobe, so TAIL_CYCLES must be >= WRITE_GAP.
    localparam int unsigned PACE_MAX = (TAIL_CYCLES > WRITE_GAP) ? TAIL_CYCLES : WRITE_GAP;
    localparam int unsigned PACE_W   = $clog2(PACE_MAX + 1);
    localparam int unsigned LANE_W   = 3;

    feeder_state_t     state;
    feeder_state_t     state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] word_q;

    logic              begin_session;
    logic              take_word;
    logic              pace_load;
    logic [PACE_W-1:0] pace_val;
    logic              pace_zero;
    logic              pace_zero_next;
    logic [BYTE_W-1:0] emit_byte;

    feeder_pace_counter #(
        .CNT_W (PACE_W)
    ) u_pace (
        .clk         (clk_ppu_21_47),
        .rst_n       (reset_n),
        .load        (pace_load),
        .load_val    (pace_val),
        .zero_c      (pace_zero),
        .zero_next_c (pace_zero_next)
    );

    assign word.word_ready = (state == WAIT_WORD);
    assign take_word       = (state == WAIT_WORD) && word.word_valid;

    // First byte of a freshly accepted word comes straight off the bus.
    assign emit_byte = take_word ? lane_byte(word.word_data, 2'd0, BIG_ENDIAN)
                                 : lane_byte(word_q, lane_q[1:0], BIG_ENDIAN);

    // Next-state and pace-counter control.
    always_comb begin
        state_nxt     = state;
        begin_session = 1'b0;
        pace_load     = 1'b0;
        pace_val      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    begin_session = 1'b1;
                    if (length == '0) begin
                        state_nxt = TAIL;
                        pace_load = 1'b1;
                        pace_val  = PACE_W'(TAIL_CYCLES);
                    end else begin
                        state_nxt = WAIT_WORD;
                    end
                end
            end
            WAIT_WORD: begin
                if (word.word_valid) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                state_nxt = GAP;
                pace_load = 1'b1;
                pace_val  = PACE_W'(WRITE_GAP - 2);
            end
            GAP: begin
                if (pace_zero) begin
                    if (count_q == len_q) begin
                        // Part of the tail has already elapsed inside this gap.
                        state_nxt = TAIL;
                        pace_load = 1'b1;
                        pace_val  = PACE_W'(TAIL_CYCLES - WRITE_GAP);
                    end else if (lane_q == LANE_W'(LANES)) begin
                        state_nxt = WAIT_WORD;
                    end else begin
                        state_nxt = EMIT;
                    end
                end
            end
            TAIL: begin
                if (pace_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, session datapath and registered outputs.
    always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            len_q          <= '0;
            count_q        <= '0;
            lane_q         <= '0;
            word_q         <= '0;
            ioctl_download <= 1'b0;
            ioctl_wr       <= 1'b0;
            ioctl_dout     <= '0;
            ioctl_addr     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (begin_session) begin
                len_q   <= length;
                count_q <= '0;
            end
            if (take_word) begin
                word_q <= word.word_data;
                lane_q <= '0;
            end
            if (state == EMIT) begin
                count_q <= count_q + LEN_W'(1);
                lane_q  <= lane_q + LANE_W'(1);
            end
            ioctl_download <= (state_nxt != IDLE);
            busy           <= (state_nxt != IDLE);
            ioctl_wr       <= (state_nxt == EMIT);
            if (state_nxt == EMIT) begin
                ioctl_dout <= emit_byte;
                ioctl_addr <= count_q;
            end
            // Lands in the final high cycle of ioctl_download.
            done <= (state_nxt == TAIL) && pace_zero_next;
        end
    end

`ifdef ROM_FEEDER_CHECKSUM_EN
    // Wrapping sum of emitted bytes; the strobed byte is folded in as the strobe ends.
    always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (begin_session) begin
            checksum <= '0;
        end else if (state == EMIT) begin
            checksum <= checksum + CSUM_W'(ioctl_dout);
        end
    end
`endif

endmodule
